// File: rtl/multi_cycle_sequencer.sv
// rtl/multi_cycle_sequencer.sv - IF/ID/EX/MEM/WB control sequencer with memory handshakes
module multi_cycle_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        is_mem,
    input  logic        is_wb,
    input  logic        is_halt,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        en_if,
    output logic        en_id,
    output logic        en_ex,
    output logic        en_mem,
    output logic        en_wb,
    output logic [2:0]  state,
    output logic        halted,
    output logic        timeout,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      cur;
    state_t      nxt;
    logic        mem_f;
    logic        wb_f;
    logic        halt_f;
    logic [7:0]  wait_cnt;
    logic        active;
    logic        retire;
    logic        set_timeout;
    logic        wait_tick;
    logic [31:0] count_next;

    // Nothing advances or requests while frozen or while reset is asserted
    assign active = run && !rst;

    assign state       = cur;
    assign halted      = (cur == S_HALT);
    assign count_next  = retire ? instr_count + 32'd1 : instr_count;

    // Next-state, handshake requests, stage enables and wait/timeout decisions
    always_comb begin
        nxt         = cur;
        retire      = 1'b0;
        set_timeout = 1'b0;
        wait_tick   = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        en_if       = 1'b0;
        en_id       = 1'b0;
        en_ex       = 1'b0;
        en_mem      = 1'b0;
        en_wb       = 1'b0;
        case (cur)
            S_IF: begin
                imem_req = active;
                if (active) begin
                    if (imem_ack) begin
                        en_if = 1'b1;
                        nxt   = S_ID;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        set_timeout = 1'b1;
                        nxt         = S_HALT;
                    end else begin
                        wait_tick = 1'b1;
                    end
                end
            end
            S_ID: begin
                en_id = active;
                if (active) begin
                    nxt = is_halt ? S_HALT : S_EX;
                end
            end
            S_EX: begin
                en_ex = active;
                if (active) begin
                    // A latched HALT never reaches EX; guard so it could never retire
                    if (halt_f) begin
                        nxt = S_HALT;
                    end else if (mem_f) begin
                        nxt = S_MEM;
                    end else if (wb_f) begin
                        nxt = S_WB;
                    end else begin
                        nxt    = S_IF;
                        retire = 1'b1;
                    end
                end
            end
            S_MEM: begin
                dmem_req = active;
                if (active) begin
                    if (dmem_ack) begin
                        en_mem = 1'b1;
                        if (wb_f) begin
                            nxt = S_WB;
                        end else begin
                            nxt    = S_IF;
                            retire = 1'b1;
                        end
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        set_timeout = 1'b1;
                        nxt         = S_HALT;
                    end else begin
                        wait_tick = 1'b1;
                    end
                end
            end
            S_WB: begin
                en_wb = active;
                if (active) begin
                    nxt    = S_IF;
                    retire = 1'b1;
                end
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: begin
                nxt = S_HALT;
            end
        endcase
    end

    // State, decoded flags, wait counter and sticky timeout fault
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_IF;
            mem_f    <= 1'b0;
            wb_f     <= 1'b0;
            halt_f   <= 1'b0;
            wait_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            cur <= nxt;
            if (active && cur == S_ID) begin
                mem_f  <= is_mem;
                wb_f   <= is_wb;
                halt_f <= is_halt;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
            if (nxt != cur && (nxt == S_IF || nxt == S_MEM)) begin
                wait_cnt <= 8'd0;
            end else if (wait_tick) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= 32'd0;
        end else begin
            instr_count <= count_next;
        end
    end

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// tb/tb_multi_cycle_sequencer.sv - scoreboard bench for multi_cycle_sequencer
module tb_multi_cycle_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_ack;
    logic        dmem_ack;
    logic        is_mem;
    logic        is_wb;
    logic        is_halt;
    logic        imem_req;
    logic        dmem_req;
    logic        en_if;
    logic        en_id;
    logic        en_ex;
    logic        en_mem;
    logic        en_wb;
    logic [2:0]  state;
    logic        halted;
    logic        timeout;
    logic [31:0] instr_count;

    localparam logic [4:0] N    = 5'b00000;
    localparam logic [4:0] EIF  = 5'b10000;
    localparam logic [4:0] EID  = 5'b01000;
    localparam logic [4:0] EEX  = 5'b00100;
    localparam logic [4:0] EMEM = 5'b00010;
    localparam logic [4:0] EWB  = 5'b00001;

    logic [43:0] expq[$];
    int          passed;
    int          total;
    int          vec_id;

    multi_cycle_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .imem_ack(imem_ack),
        .dmem_ack(dmem_ack),
        .is_mem(is_mem),
        .is_wb(is_wb),
        .is_halt(is_halt),
        .imem_req(imem_req),
        .dmem_req(dmem_req),
        .en_if(en_if),
        .en_id(en_id),
        .en_ex(en_ex),
        .en_mem(en_mem),
        .en_wb(en_wb),
        .state(state),
        .halted(halted),
        .timeout(timeout),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every presented cycle against the next scoreboard entry
    always @(negedge clk) begin
        logic [43:0] e;
        logic [43:0] a;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            a = {state, imem_req, dmem_req, en_if, en_id, en_ex, en_mem, en_wb, halted, timeout, instr_count};
            total = total + 1;
            if (a === e) begin
                passed = passed + 1;
            end else begin
                $display("FAIL cycle%0d: got st=%0d ireq=%b dreq=%b en=%b hlt=%b to=%b cnt=%h, want st=%0d ireq=%b dreq=%b en=%b hlt=%b to=%b cnt=%h",
                         vec_id, a[43:41], a[40], a[39], a[38:34], a[33], a[32], a[31:0],
                         e[43:41], e[40], e[39], e[38:34], e[33], e[32], e[31:0]);
            end
            vec_id = vec_id + 1;
        end
    end

    task automatic step(input logic r, input logic ru, input logic ia, input logic da,
                        input logic m, input logic w, input logic h,
                        input logic [2:0] st, input logic ireq, input logic dreq,
                        input logic [4:0] en, input logic hl, input logic to,
                        input logic [31:0] cnt);
        rst      = r;
        run      = ru;
        imem_ack = ia;
        dmem_ack = da;
        is_mem   = m;
        is_wb    = w;
        is_halt  = h;
        expq.push_back({st, ireq, dreq, en, hl, to, cnt});
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        vec_id   = 0;
        rst      = 1'b1;
        run      = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        is_mem   = 1'b0;
        is_wb    = 1'b0;
        is_halt  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: outputs gated even with run and acks high
        step(1,1,1,1,0,0,0, 3'd0,0,0,N,0,0,32'd0);

        // Load with immediate acks: five stage pulses, retire after WB
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd0);
        step(0,1,0,0,1,1,0, 3'd1,0,0,EID,0,0,32'd0);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'd0);
        step(0,1,0,1,0,0,0, 3'd3,0,1,EMEM,0,0,32'd0);
        step(0,1,0,0,0,0,0, 3'd4,0,0,EWB,0,0,32'd0);

        // Load with 3 imem and 2 dmem wait cycles: 10 cycles total
        for (int i = 0; i < 3; i++) step(0,1,0,0,0,0,0, 3'd0,1,0,N,0,0,32'd1);
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd1);
        step(0,1,0,0,1,1,0, 3'd1,0,0,EID,0,0,32'd1);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'd1);
        for (int i = 0; i < 2; i++) step(0,1,0,0,0,0,0, 3'd3,0,1,N,0,0,32'd1);
        step(0,1,0,1,0,0,0, 3'd3,0,1,EMEM,0,0,32'd1);
        step(0,1,0,0,0,0,0, 3'd4,0,0,EWB,0,0,32'd1);

        // Store with a 5-cycle run=0 stall in MEM and a dmem_ack during the stall
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd2);
        step(0,1,0,0,1,0,0, 3'd1,0,0,EID,0,0,32'd2);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'd2);
        step(0,1,0,0,0,0,0, 3'd3,0,1,N,0,0,32'd2);
        step(0,0,0,0,0,0,0, 3'd3,0,0,N,0,0,32'd2);
        step(0,0,0,1,0,0,0, 3'd3,0,0,N,0,0,32'd2);
        for (int i = 0; i < 3; i++) step(0,0,0,0,0,0,0, 3'd3,0,0,N,0,0,32'd2);
        step(0,1,0,0,0,0,0, 3'd3,0,1,N,0,0,32'd2);
        step(0,1,0,1,0,0,0, 3'd3,0,1,EMEM,0,0,32'd2);

        // Stray dmem_ack in IF has no effect
        step(0,1,0,1,0,0,0, 3'd0,1,0,N,0,0,32'd3);

        // ALU without writeback: 3 cycles
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd3);
        step(0,1,0,0,0,0,0, 3'd1,0,0,EID,0,0,32'd3);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'd3);

        // ALU with writeback: 4 cycles
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd4);
        step(0,1,0,0,0,1,0, 3'd1,0,0,EID,0,0,32'd4);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'd4);
        step(0,1,0,0,0,0,0, 3'd4,0,0,EWB,0,0,32'd4);

        // Reset asserted in MEM of a load: access abandoned, count cleared
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd5);
        step(0,1,0,0,1,1,0, 3'd1,0,0,EID,0,0,32'd5);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'd5);
        step(1,1,0,1,0,0,0, 3'd3,0,0,N,0,0,32'd5);
        step(0,1,0,0,0,0,0, 3'd0,1,0,N,0,0,32'd0);

        // One ALU retire, then HALT in ID leaves the count unchanged
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd0);
        step(0,1,0,0,0,0,0, 3'd1,0,0,EID,0,0,32'd0);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'd0);
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'd1);
        step(0,1,0,0,1,1,1, 3'd1,0,0,EID,0,0,32'd1);
        for (int i = 0; i < 2; i++) step(0,1,1,1,0,0,0, 3'd5,0,0,N,1,0,32'd1);
        step(1,0,0,0,0,0,0, 3'd5,0,0,N,1,0,32'd1);

        // Counter wrap: preload 0xFFFFFFFF while frozen, then retire one ALU op
        force dut.count_next = 32'hFFFF_FFFF;
        step(0,0,0,0,0,0,0, 3'd0,0,0,N,0,0,32'd0);
        release dut.count_next;
        step(0,0,0,0,0,0,0, 3'd0,0,0,N,0,0,32'hFFFF_FFFF);
        step(0,1,1,0,0,0,0, 3'd0,1,0,EIF,0,0,32'hFFFF_FFFF);
        step(0,1,0,0,0,0,0, 3'd1,0,0,EID,0,0,32'hFFFF_FFFF);
        step(0,1,0,0,0,0,0, 3'd2,0,0,EEX,0,0,32'hFFFF_FFFF);

        // Timeout with TIMEOUT=4: five request cycles, then sticky fault and HALT
        for (int i = 0; i < 5; i++) step(0,1,0,0,0,0,0, 3'd0,1,0,N,0,0,32'd0);
        for (int i = 0; i < 2; i++) step(0,1,1,1,0,0,0, 3'd5,0,0,N,1,1,32'd0);
        step(1,1,1,0,0,0,0, 3'd5,0,0,N,1,1,32'd0);
        step(0,1,0,0,0,0,0, 3'd0,1,0,N,0,0,32'd0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
        if (expq.size() != 0) begin
            total = total + 1;
            $display("FAIL drain: %0d entries left, want 0", expq.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
